// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default geometry, owner tags
// and starvation-guard defaults.
package dmem_pkg;

   localparam int AW_DEF       = 8;
   localparam int DW_DEF       = 32;
   localparam int MAX_WAIT_DEF = 4;
   localparam int CNT_W        = 4;

   typedef enum logic {
      OWN_C = 1'b0,
      OWN_D = 1'b1
   } owner_e;

endpackage

// File: rtl/dmem_arbiter_starve_cnt.sv
// Saturating wait counter for the secondary port; clear wins over increment,
// and sat is a registered copy of (count == MAX_WAIT).
module starve_cnt
   import dmem_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);

   localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (inc && (cnt_q != MAX_V)) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
      sat_d = (cnt_d == MAX_V);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= {CNT_W{1'b0}};
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sat_q <= sat_d;
      end
   end

   assign cnt = cnt_q;
   assign sat = sat_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage (C, primary)
// and the debug/loader master (D), returning read data one cycle after grant.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout,
   output logic          starve
);

   localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] wait_cnt;
   logic             force_s;
   logic             cnt_inc_s;
   logic             cnt_clr_s;

   logic             rd_pend_q,  rd_pend_d;
   owner_e           rd_owner_q, rd_owner_d;
   logic [DW-1:0]    rdata_q,    rdata_d;

   starve_cnt #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve_cnt (
      .clk (clk),
      .rst (rst),
      .inc (cnt_inc_s),
      .clr (cnt_clr_s),
      .cnt (wait_cnt),
      .sat (starve)
   );

   // Grants are masked by rst so nothing reaches the memory while reset is held.
   always_comb begin
      force_s   = d_req & (wait_cnt == MAX_V);
      d_gnt     = rst & d_req & (~c_req | force_s);
      c_gnt     = rst & c_req & ~d_gnt;
      cnt_inc_s = d_req & ~d_gnt;
      cnt_clr_s = d_gnt | ~d_req;
   end

   always_comb begin
      mem_we   = 1'b0;
      mem_addr = {AW{1'b0}};
      mem_din  = {DW{1'b0}};
      if (d_gnt) begin
         mem_we   = d_we;
         mem_addr = d_addr;
         mem_din  = d_wdata;
      end else if (c_gnt) begin
         mem_we   = c_we;
         mem_addr = c_addr;
         mem_din  = c_wdata;
      end else begin
         mem_we   = 1'b0;
         mem_addr = {AW{1'b0}};
         mem_din  = {DW{1'b0}};
      end
   end

   // dmem updates douta on the falling edge of the grant cycle, so it is
   // stable at the next rising edge where it is captured for the owner.
   always_comb begin
      rd_pend_d  = (c_gnt & ~c_we) | (d_gnt & ~d_we);
      rd_owner_d = rd_owner_q;
      rdata_d    = {DW{1'b0}};
      if (rd_pend_d) begin
         rd_owner_d = d_gnt ? OWN_D : OWN_C;
         rdata_d    = mem_dout;
      end else begin
         rd_owner_d = rd_owner_q;
         rdata_d    = {DW{1'b0}};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_pend_q  <= 1'b0;
         rd_owner_q <= OWN_C;
         rdata_q    <= {DW{1'b0}};
      end else begin
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
         rdata_q    <= rdata_d;
      end
   end

   always_comb begin
      c_rvalid = rd_pend_q & (rd_owner_q == OWN_C);
      d_rvalid = rd_pend_q & (rd_owner_q == OWN_D);
      c_rdata  = {DW{1'b0}};
      d_rdata  = {DW{1'b0}};
      if (c_rvalid) begin
         c_rdata = rdata_q;
      end else if (d_rvalid) begin
         d_rdata = rdata_q;
      end else begin
         c_rdata = {DW{1'b0}};
         d_rdata = {DW{1'b0}};
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: grants checked per cycle, read returns
// checked by a scoreboard monitor against hand-computed expectations.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        c_req, c_we, d_req, d_we;
   logic [7:0]  c_addr, d_addr;
   logic [31:0] c_wdata, d_wdata;
   logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
   logic [31:0] c_rdata, d_rdata;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout = 32'h0;
   logic        starve;

   logic [31:0] mem [0:255];

   typedef struct packed {
      logic        own;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;
   bit   exp_pend = 1'b0;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(8), .DW(32), .MAX_WAIT(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .c_req    (c_req),
      .c_we     (c_we),
      .c_addr   (c_addr),
      .c_wdata  (c_wdata),
      .c_gnt    (c_gnt),
      .c_rvalid (c_rvalid),
      .c_rdata  (c_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout),
      .starve   (starve)
   );

   // dmem model, clocked on the falling edge, read-first
   always @(negedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_din;
      mem_dout <= mem[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic own, input logic [31:0] data);
      exp_t e;
      e.own  = own;
      e.data = data;
      sb_q.push_back(e);
   endtask

   // One cycle of stimulus; entered and left at posedge+2.
   task automatic step(input logic cr, input logic cw, input logic [7:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [7:0] da, input logic [31:0] dd,
                       input logic ecg, input logic edg, input logic est);
      c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
      d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
      #2;
      chk("c_gnt", c_gnt, ecg);
      chk("d_gnt", d_gnt, edg);
      chk("starve", starve, est);
      chk("rvalid_timing", c_rvalid | d_rvalid, exp_pend);
      if (edg) begin
         chk("mem_we_d", mem_we, dw);
         chk("mem_addr_d", mem_addr, da);
         if (dw) chk("mem_din_d", mem_din, dd);
      end else if (ecg) begin
         chk("mem_we_c", mem_we, cw);
         chk("mem_addr_c", mem_addr, ca);
         if (cw) chk("mem_din_c", mem_din, cd);
      end else begin
         chk("idle_mem_we", mem_we, 1'b0);
         chk("idle_mem_addr", mem_addr, 8'h00);
      end
      exp_pend = (ecg & ~cw) | (edg & ~dw);
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   // Scoreboard monitor: every rvalid must match the head of the queue.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #3;
         if (c_rvalid || d_rvalid) begin
            chk("rvalid_onehot", c_rvalid & d_rvalid, 1'b0);
            if (sb_q.size() == 0) begin
               chk("rvalid_unexpected", {30'h0, c_rvalid, d_rvalid}, 32'h0);
            end else begin
               e = sb_q.pop_front();
               chk("rd_owner", d_rvalid, e.own);
               chk("rd_data", e.own ? d_rdata : c_rdata, e.data);
               chk("rd_other_zero", e.own ? c_rdata : d_rdata, 32'h0);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h10] = 32'hDEADBEEF;
      mem[8'h01] = 32'hA1A10001;
      mem[8'h02] = 32'hB2B20002;
      mem[8'h03] = 32'hC3C30003;

      // reset held with C requesting
      rst = 1'b0;
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10; c_wdata = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_c_gnt", c_gnt, 1'b0);
      chk("rst_d_gnt", d_gnt, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_c_rvalid", c_rvalid, 1'b0);
      chk("rst_d_rvalid", d_rvalid, 1'b0);
      chk("rst_c_rdata", c_rdata, 32'h0);
      chk("rst_starve", starve, 1'b0);

      // release: C read of 0x10 granted in the first cycle
      rst = 1'b1;
      push(1'b0, 32'hDEADBEEF);
      step(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
      idle();

      // contention: C wins 4 cycles, D forced on the 5th, C again on the 6th
      for (int k = 0; k < 4; k++) begin
         push(1'b0, 32'hA1A10001);
         step(1'b1, 1'b0, 8'h01, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0, 1'b1, 1'b0, 1'b0);
      end
      push(1'b1, 32'hB2B20002);
      step(1'b1, 1'b0, 8'h01, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0, 1'b0, 1'b1, 1'b1);
      push(1'b0, 32'hC3C30003);
      step(1'b1, 1'b0, 8'h03, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0, 1'b1, 1'b0, 1'b0);
      push(1'b1, 32'hB2B20002);
      step(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h02, 32'h0, 1'b0, 1'b1, 1'b0);
      idle();

      // D write then C read of the same word
      step(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 8'h20, 32'h12345678, 1'b0, 1'b1, 1'b0);
      push(1'b0, 32'h12345678);
      step(1'b1, 1'b0, 8'h20, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
      idle();

      // reset lands in the cycle after a C read grant: the return is dropped
      step(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      c_req = 1'b0;
      #1;
      chk("rst_drop_c_rvalid", c_rvalid, 1'b0);
      chk("rst_drop_d_rvalid", d_rvalid, 1'b0);
      chk("rst_drop_c_rdata", c_rdata, 32'h0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      exp_pend = 1'b0;
      idle();
      idle();

      chk("sb_empty", sb_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
